// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: default operand width,
// opcode encodings and the issue FSM state encoding.
package alu_pkg;

    localparam int unsigned WIDTH_DEFAULT = 8;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_XOR = 3'd2;
    localparam logic [2:0] OP_NOT = 3'd3;
    localparam logic [2:0] OP_ADD = 3'd4;
    localparam logic [2:0] OP_SUB = 3'd5;
    localparam logic [2:0] OP_SHL = 3'd6;
    localparam logic [2:0] OP_SHR = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_shift_unit.sv
// Iterative one-bit-per-cycle shifter for the ALU issue stage.
// It holds the latched operand (shift register), the latched shift count
// and the last bit shifted out.
module alu_shift_unit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic             dir_right,
    input  logic [WIDTH-1:0] din,
    input  logic [2:0]       cnt_in,
    output logic [WIDTH-1:0] dout,
    output logic             cnt_zero,
    output logic             cout
);

    logic [WIDTH-1:0] sr_q;
    logic [2:0]       cnt_q;
    logic             co_q;

    // Load operand/count on accept, otherwise shift by one bit per step.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr_q  <= '0;
            cnt_q <= '0;
            co_q  <= 1'b0;
        end else if (load) begin
            sr_q  <= din;
            cnt_q <= cnt_in;
            co_q  <= 1'b0;
        end else if (step) begin
            cnt_q <= cnt_q - 3'd1;
            if (dir_right) begin
                sr_q <= {1'b0, sr_q[WIDTH-1:1]};
                co_q <= sr_q[0];
            end else begin
                sr_q <= {sr_q[WIDTH-2:0], 1'b0};
                co_q <= sr_q[WIDTH-1];
            end
        end
    end

    assign dout     = sr_q;
    assign cnt_zero = (cnt_q == 3'd0);
    assign cout     = co_q;

endmodule

// File: rtl/alu_issue_stage.sv
// Registered issue stage for the 8-bit logic/arithmetic units.
// Valid/ready in, valid/ready out; single-cycle ops complete at the accept
// edge, shifts run iteratively in alu_shift_unit.
// Optional feature macro: ALU_SHIFT_EN (enables SHL/SHR; otherwise
// opcodes 6/7 complete immediately with ERR=1).
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VLD,
    output logic             IN_RDY,
    input  logic [2:0]       OP,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             OUT_VLD,
    input  logic             OUT_RDY,
    output logic [WIDTH-1:0] F,
    output logic             ZF,
    output logic             CF,
    output logic             NF,
    output logic             ERR
);

    state_t           state_q, state_d;
    logic             accept;
    logic             is_shift;
    logic [WIDTH-1:0] res_w;
    logic [WIDTH:0]   sum_w;
    logic             cf_w;
    logic             err_w;

    logic [WIDTH-1:0] f_q;
    logic             zf_q, cf_q, nf_q, err_q, out_vld_q;

`ifdef ALU_SHIFT_EN
    logic [2:0]       op_q;
    logic             shift_step;
    logic [WIDTH-1:0] sh_dout;
    logic             sh_cnt_zero;
    logic             sh_cout;
`endif

    assign IN_RDY = (state_q == ST_IDLE) && (!out_vld_q || OUT_RDY);
    assign accept = IN_VLD && IN_RDY;

`ifdef ALU_SHIFT_EN
    assign is_shift = (OP == OP_SHL) || (OP == OP_SHR);
`else
    assign is_shift = 1'b0;
`endif

    // Single-cycle result and carry/borrow for opcodes 0-5.
    always_comb begin
        res_w = '0;
        sum_w = '0;
        cf_w  = 1'b0;
        err_w = 1'b0;
        case (OP)
            OP_AND: res_w = A & B;
            OP_OR:  res_w = A | B;
            OP_XOR: res_w = A ^ B;
            OP_NOT: res_w = ~A;
            OP_ADD: begin
                sum_w = {1'b0, A} + {1'b0, B};
                res_w = sum_w[WIDTH-1:0];
                cf_w  = sum_w[WIDTH];
            end
            OP_SUB: begin
                // No carry out of A + ~B + 1 means a borrow occurred.
                sum_w = {1'b0, A} + {1'b0, ~B} + (WIDTH+1)'(1);
                res_w = sum_w[WIDTH-1:0];
                cf_w  = ~sum_w[WIDTH];
            end
            default: begin
`ifndef ALU_SHIFT_EN
                err_w = 1'b1;
`endif
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (!RST_N) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state: a zero count still spends one cycle in SHIFT.
    always_comb begin
        state_d = state_q;
`ifdef ALU_SHIFT_EN
        shift_step = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept && is_shift) state_d = ST_SHIFT;
            end
`ifdef ALU_SHIFT_EN
            ST_SHIFT: begin
                if (sh_cnt_zero) state_d = ST_DONE;
                else             shift_step = 1'b1;
            end
            ST_DONE: state_d = ST_IDLE;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef ALU_SHIFT_EN
    // Latch the opcode on accept so the shift direction is stable.
    always_ff @(posedge CLK) begin
        if (!RST_N)      op_q <= OP_AND;
        else if (accept) op_q <= OP;
    end

    alu_shift_unit #(.WIDTH(WIDTH)) u_shift (
        .clk       (CLK),
        .rst_n     (RST_N),
        .load      (accept),
        .step      (shift_step),
        .dir_right (op_q == OP_SHR),
        .din       (A),
        .cnt_in    (B[2:0]),
        .dout      (sh_dout),
        .cnt_zero  (sh_cnt_zero),
        .cout      (sh_cout)
    );
`endif

    // Output register: written by single-cycle accepts or by shift completion,
    // valid cleared when consumed.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            f_q       <= '0;
            zf_q      <= 1'b0;
            cf_q      <= 1'b0;
            nf_q      <= 1'b0;
            err_q     <= 1'b0;
            out_vld_q <= 1'b0;
        end else if (accept && !is_shift) begin
            f_q       <= res_w;
            zf_q      <= (res_w == '0);
            cf_q      <= cf_w;
            nf_q      <= res_w[WIDTH-1];
            err_q     <= err_w;
            out_vld_q <= 1'b1;
`ifdef ALU_SHIFT_EN
        end else if (state_q == ST_DONE) begin
            f_q       <= sh_dout;
            zf_q      <= (sh_dout == '0);
            cf_q      <= sh_cout;
            nf_q      <= sh_dout[WIDTH-1];
            err_q     <= 1'b0;
            out_vld_q <= 1'b1;
`endif
        end else if (OUT_RDY) begin
            out_vld_q <= 1'b0;
        end
    end

    assign F       = f_q;
    assign ZF      = zf_q;
    assign CF      = cf_q;
    assign NF      = nf_q;
    assign ERR     = err_q;
    assign OUT_VLD = out_vld_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage.
// Honours ALU_SHIFT_EN the same way as the design.
module tb_alu_issue_stage;

    logic       CLK;
    logic       RST_N;
    logic       IN_VLD;
    logic       IN_RDY;
    logic [2:0] OP;
    logic [7:0] A;
    logic [7:0] B;
    logic       OUT_VLD;
    logic       OUT_RDY;
    logic [7:0] F;
    logic       ZF, CF, NF, ERR;

    int unsigned n_vec;
    int unsigned n_err;

    alu_issue_stage #(.WIDTH(8)) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .IN_VLD  (IN_VLD),
        .IN_RDY  (IN_RDY),
        .OP      (OP),
        .A       (A),
        .B       (B),
        .OUT_VLD (OUT_VLD),
        .OUT_RDY (OUT_RDY),
        .F       (F),
        .ZF      (ZF),
        .CF      (CF),
        .NF      (NF),
        .ERR     (ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_res(input string tag, input logic [7:0] f, input logic zf,
                           input logic cf, input logic nf, input logic err);
        check({tag, ".vld"}, 16'(OUT_VLD), 16'(1));
        check({tag, ".F"},   16'(F),   16'(f));
        check({tag, ".ZF"},  16'(ZF),  16'(zf));
        check({tag, ".CF"},  16'(CF),  16'(cf));
        check({tag, ".NF"},  16'(NF),  16'(nf));
        check({tag, ".ERR"}, 16'(ERR), 16'(err));
    endtask

    // Present one op for exactly one edge.
    task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        IN_VLD = 1'b1;
        OP     = op;
        A      = a;
        B      = b;
        tick();
        IN_VLD = 1'b0;
    endtask

    // Issue a shift, measure accept-to-valid latency with IN_RDY held low.
    task automatic run_shift(input string tag, input logic [2:0] op, input logic [7:0] a,
                             input logic [7:0] b, input logic [7:0] f, input logic cf,
                             input int unsigned lat);
        int unsigned cyc;
        issue(op, a, b);
        cyc = 0;
        while (!OUT_VLD && cyc < 20) begin
            check({tag, ".rdy"}, 16'(IN_RDY), 16'(0));
            tick();
            cyc++;
        end
        check({tag, ".lat"}, 16'(cyc), 16'(lat));
        chk_res(tag, f, (f == 8'h00), cf, f[7], 1'b0);
        tick();
        check({tag, ".clr"}, 16'(OUT_VLD), 16'(0));
    endtask

    initial begin
        int unsigned seen;
        n_vec   = 0;
        n_err   = 0;
        RST_N   = 1'b0;
        IN_VLD  = 1'b0;
        OUT_RDY = 1'b1;
        OP      = 3'd0;
        A       = 8'h00;
        B       = 8'h00;

        // Reset held for two edges.
        tick();
        tick();
        RST_N = 1'b1;
        check("rst.vld", 16'(OUT_VLD), 16'(0));
        check("rst.rdy", 16'(IN_RDY),  16'(1));
        check("rst.F",   16'(F),       16'(0));
        check("rst.flg", 16'({ZF, CF, NF, ERR}), 16'(0));
        tick();
        tick();
        check("idle.vld", 16'(OUT_VLD), 16'(0));
        check("idle.rdy", 16'(IN_RDY),  16'(1));

        // OR
        issue(3'd1, 8'h87, 8'h0A);
        chk_res("or1", 8'h8F, 1'b0, 1'b0, 1'b1, 1'b0);
        issue(3'd1, 8'h01, 8'h01);
        chk_res("or2", 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);

        // ADD then SUB back to back
        IN_VLD = 1'b1; OP = 3'd4; A = 8'hFF; B = 8'h7B;
        tick();
        chk_res("add", 8'h7A, 1'b0, 1'b1, 1'b0, 1'b0);
        check("b2b.rdy", 16'(IN_RDY), 16'(1));
        OP = 3'd5; A = 8'h01; B = 8'h01;
        tick();
        IN_VLD = 1'b0;
        chk_res("sub0", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

        // Borrow and NOT
        issue(3'd5, 8'h01, 8'h02);
        chk_res("subb", 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0);
        issue(3'd3, 8'h0F, 8'h55);
        chk_res("not", 8'hF0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        check("drain.vld", 16'(OUT_VLD), 16'(0));

        // Shifts
`ifdef ALU_SHIFT_EN
        run_shift("shl3", 3'd6, 8'h81, 8'h03, 8'h08, 1'b0, 5);
        run_shift("shr1", 3'd7, 8'hB1, 8'hF9, 8'h58, 1'b1, 3);
        run_shift("shl0", 3'd6, 8'h81, 8'h08, 8'h81, 1'b0, 2);
`else
        issue(3'd6, 8'h81, 8'h03);
        chk_res("shl.off", 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
        issue(3'd7, 8'h80, 8'h07);
        chk_res("shr.off", 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
`endif

        // Backpressure: XOR held while the next AND waits on the inputs
        OUT_RDY = 1'b0;
        issue(3'd2, 8'hF0, 8'hFF);
        IN_VLD = 1'b1; OP = 3'd0; A = 8'h3C; B = 8'h0F;
        for (int i = 0; i < 3; i++) begin
            chk_res("bp.hold", 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);
            check("bp.rdy", 16'(IN_RDY), 16'(0));
            tick();
        end
        OUT_RDY = 1'b1;
        #1;
        check("bp.rdy1", 16'(IN_RDY), 16'(1));
        tick();
        IN_VLD = 1'b0;
        chk_res("bp.and", 8'h0C, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("bp.clr", 16'(OUT_VLD), 16'(0));

        // Reset while an op is in flight or pending
`ifdef ALU_SHIFT_EN
        issue(3'd7, 8'h80, 8'h07);
        tick();
        tick();
`else
        OUT_RDY = 1'b0;
        issue(3'd7, 8'h80, 8'h07);
        tick();
        OUT_RDY = 1'b1;
`endif
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        check("mrst.vld", 16'(OUT_VLD), 16'(0));
        check("mrst.rdy", 16'(IN_RDY),  16'(1));
        check("mrst.flg", 16'({ZF, CF, NF, ERR}), 16'(0));
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (OUT_VLD) seen++;
            tick();
        end
        check("mrst.quiet", 16'(seen), 16'(0));
        issue(3'd4, 8'h01, 8'h02);
        chk_res("mrst.next", 8'h03, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
